multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore-style main controller for the multicycle MIPS-subset core.
- Sequences fetch, decode, execute, memory and writeback states from the instruction register's opcode/funct fields.
- Drives every datapath mux select and write strobe.
- Both instruction/data memory and the register file have synchronous reads, so wait states are explicit.

Parameters:
- none (all encodings are package constants)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- opcode  in  6  inst_reg[31:26]
- funct  in  6  inst_reg[5:0]
- IorD  out  1  memory address: 0=PC, 1=alu_out
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load; datapath computes pcen = PCWrite | (Branch & (ToggleEqual ^ zero))
- ToggleEqual  out  1  0=beq, 1=bne
- PCSrc  out  2  next-PC source: 00 alu_result, 01 alu_out, 10 jump address
- ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ALUSrcB  out  2  ALU B operand: 00 rt register, 01 constant 4, 10 SignImm, 11 SignImm<<2
- ALUSrcA  out  1  ALU A operand: 0=PC, 1=rs register
- RegWrite  out  1  register file write strobe
- RegDst  out  2  destination register: 00 rt, 01 rd, 10 r31
- MemtoReg  out  2  writeback source: 00 alu_out, 01 data_reg, 10 PC
- state  out  5  current state, for debug

Behaviour:
- State register updates on the clk rising edge. rst=1 at an edge forces FETCH(0).
- While rst=1, MemWrite, IRWrite, PCWrite, Branch and RegWrite are forced to 0 combinationally.
- Outputs are a function of state only, with three exceptions:
  - ALUControl in EXECUTE comes from funct.
  - ToggleEqual in BRANCH comes from opcode.
  - ALUControl in IMM_EXEC comes from opcode.
- Unlisted outputs are 0; strobes default to 0.
- States and transitions (name, encoding: outputs -> next state):
  - FETCH 0: IorD=0 -> 1.
  - FETCH_IR 1: IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00 -> 2.
  - DECODE 2: register read issued -> 3.
  - DECODE_WAIT 3: ALUSrcA=0, ALUSrcB=11, ADD, so alu_out holds the branch target. Dispatch on opcode:
    - lw 100011, sw 101011 -> 4
    - R-type 000000 with funct jr 001000 -> 16
    - other R-type -> 9
    - beq 000100, bne 000101 -> 11
    - addi 001000, slti 001010 -> 12
    - j 000010 -> 14
    - jal 000011 -> 15
    - anything else -> FETCH
  - MEM_ADR 4: ALUSrcA=1, ALUSrcB=10, ADD. lw -> 5, sw -> 8.
  - MEM_READ 5: IorD=1 -> 6.
  - MEM_WAIT 6: IorD=1 -> 7.
  - MEM_WB 7: RegDst=00, MemtoReg=01, RegWrite -> 0.
  - MEM_WRITE 8: IorD=1, MemWrite -> 0.
  - EXECUTE 9: ALUSrcA=1, ALUSrcB=00, ALUControl by funct -> 10.
    - add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000; or 100101 -> 001; slt 101010 -> 111; else 010.
  - ALU_WB 10: RegDst=01, MemtoReg=00, RegWrite -> 0.
  - BRANCH 11: ALUSrcA=1, ALUSrcB=00, SUB, Branch, PCSrc=01, ToggleEqual=opcode[0] -> 0.
  - IMM_EXEC 12: ALUSrcA=1, ALUSrcB=10, ADD (addi) or SLT (slti) -> 13.
  - IMM_WB 13: RegDst=00, MemtoReg=00, RegWrite -> 0.
  - JUMP 14: PCSrc=10, PCWrite -> 0.
  - JAL 15: PCSrc=10, PCWrite, RegWrite, RegDst=10, MemtoReg=10 (PC already +4) -> 0.
  - JR 16: ALUSrcA=1, ALUSrcB=00, OR (rt field is $zero), PCSrc=00, PCWrite -> 0.
- Unused encodings 17-31 -> FETCH next cycle, all strobes 0.
- Cycle counts from FETCH back to FETCH:
  - lw 8; sw 6; R-type 6; branch 5; imm 6; j/jal/jr 5.

Optional Feature:
- MCU_ILLEGAL_HALT_EN defined:
  - Undecoded opcode/funct in DECODE_WAIT goes to HALT (31).
  - HALT holds all strobes 0 and stays until rst.
- Undefined (default): undecoded instructions return to FETCH, i.e. are executed as NOPs.

Decomposition:
- Package mcu_pkg holds:
  - state encodings
  - opcode and funct constants
  - ALUControl codes
  - PCSrc/ALUSrcB/RegDst/MemtoReg select encodings
- One sub-module, mcu_alu_decoder: funct -> ALUControl.

Test Plan:
- rst high 2 cycles, then low -> state=0, all strobes 0 during reset; state sequence 0,1,2,3.
- opcode 100011 -> states 4,5,6,7,0; RegWrite=1 only in 7 with MemtoReg=01, RegDst=00.
- opcode 000000 funct 100010 -> state 9 with ALUControl=110; state 10 with RegDst=01, RegWrite=1.
- opcode 000101 -> state 11 with Branch=1, ToggleEqual=1, PCSrc=01, ALUControl=110; opcode 000100 gives ToggleEqual=0.
- opcode 000011 -> state 15 with PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSrc=10.
- opcode 111111 -> returns to state 0 (HALT=31 with MCU_ILLEGAL_HALT_EN); rst asserted in state 8 -> MemWrite=0 that cycle, state=0 next.

Source files
------------

// File: rtl/mcu_pkg.sv
// ============================================================================
// Package : mcu_pkg
// State, opcode/funct, ALU and mux-select encodings for the multicycle control.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mcu_pkg;

  typedef enum logic [4:0] {
    S_FETCH       = 5'd0,
    S_FETCH_IR    = 5'd1,
    S_DECODE      = 5'd2,
    S_DECODE_WAIT = 5'd3,
    S_MEM_ADR     = 5'd4,
    S_MEM_READ    = 5'd5,
    S_MEM_WAIT    = 5'd6,
    S_MEM_WB      = 5'd7,
    S_MEM_WRITE   = 5'd8,
    S_EXECUTE     = 5'd9,
    S_ALU_WB      = 5'd10,
    S_BRANCH      = 5'd11,
    S_IMM_EXEC    = 5'd12,
    S_IMM_WB      = 5'd13,
    S_JUMP        = 5'd14,
    S_JAL         = 5'd15,
    S_JR          = 5'd16,
    S_HALT        = 5'd31
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_DATA   = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // True for the R-type funct codes the datapath actually implements.
  function automatic logic funct_known(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_JR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_alu_decoder.sv
// ============================================================================
// Module  : mcu_alu_decoder
// R-type funct field to ALUControl; unknown funct codes fall back to ADD.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mcu_alu_decoder
  import mcu_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_funct)
      FN_ADD:  o_alu_control = ALU_ADD;
      FN_SUB:  o_alu_control = ALU_SUB;
      FN_AND:  o_alu_control = ALU_AND;
      FN_OR:   o_alu_control = ALU_OR;
      FN_SLT:  o_alu_control = ALU_SLT;
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module  : multicycle_control_fsm
// Moore main controller for the multicycle MIPS-subset core.
// Optional: define MCU_ILLEGAL_HALT_EN to trap undecoded instructions in HALT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       ToggleEqual,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [4:0] state
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_dispatch;
  logic [2:0] w_funct_alu;

  logic       w_iord;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_toggle_equal;
  logic [1:0] w_pc_src;
  logic [2:0] w_alu_control;
  logic [1:0] w_alu_srcb;
  logic       w_alu_srca;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;

  mcu_alu_decoder u_alu_decoder (
    .i_funct       (funct),
    .o_alu_control (w_funct_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Instruction dispatch out of DECODE_WAIT.
  always_comb begin
`ifdef MCU_ILLEGAL_HALT_EN
    w_dispatch = S_HALT;
`else
    w_dispatch = S_FETCH;
`endif
    case (opcode)
      OP_LW, OP_SW:   w_dispatch = S_MEM_ADR;
      OP_RTYPE: begin
        if (funct == FN_JR) w_dispatch = S_JR;
`ifdef MCU_ILLEGAL_HALT_EN
        else if (funct_known(funct)) w_dispatch = S_EXECUTE;
`else
        else w_dispatch = S_EXECUTE;
`endif
      end
      OP_BEQ, OP_BNE:   w_dispatch = S_BRANCH;
      OP_ADDI, OP_SLTI: w_dispatch = S_IMM_EXEC;
      OP_J:             w_dispatch = S_JUMP;
      OP_JAL:           w_dispatch = S_JAL;
      default: ;
    endcase
  end

  always_comb begin
    w_next         = S_FETCH;
    w_iord         = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_branch       = 1'b0;
    w_toggle_equal = 1'b0;
    w_pc_src       = PCSRC_ALU;
    w_alu_control  = ALU_AND;
    w_alu_srcb     = SRCB_RT;
    w_alu_srca     = SRCA_PC;
    w_reg_write    = 1'b0;
    w_reg_dst      = DST_RT;
    w_mem_to_reg   = WB_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_iord = 1'b0;
        w_next = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        w_ir_write    = 1'b1;
        w_pc_write    = 1'b1;
        w_alu_srca    = SRCA_PC;
        w_alu_srcb    = SRCB_FOUR;
        w_alu_control = ALU_ADD;
        w_pc_src      = PCSRC_ALU;
        w_next        = S_DECODE;
      end
      S_DECODE: w_next = S_DECODE_WAIT;
      S_DECODE_WAIT: begin
        // Precompute the branch target into alu_out while dispatching.
        w_alu_srca    = SRCA_PC;
        w_alu_srcb    = SRCB_IMMSH;
        w_alu_control = ALU_ADD;
        w_next        = w_dispatch;
      end
      S_MEM_ADR: begin
        w_alu_srca    = SRCA_RS;
        w_alu_srcb    = SRCB_IMM;
        w_alu_control = ALU_ADD;
        w_next        = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_iord = 1'b1;
        w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        w_iord = 1'b1;
        w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_dst    = DST_RT;
        w_mem_to_reg = WB_DATA;
        w_reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        w_alu_srca    = SRCA_RS;
        w_alu_srcb    = SRCB_RT;
        w_alu_control = w_funct_alu;
        w_next        = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_dst    = DST_RD;
        w_mem_to_reg = WB_ALUOUT;
        w_reg_write  = 1'b1;
      end
      S_BRANCH: begin
        w_alu_srca     = SRCA_RS;
        w_alu_srcb     = SRCB_RT;
        w_alu_control  = ALU_SUB;
        w_branch       = 1'b1;
        w_pc_src       = PCSRC_ALUOUT;
        w_toggle_equal = opcode[0];
      end
      S_IMM_EXEC: begin
        w_alu_srca    = SRCA_RS;
        w_alu_srcb    = SRCB_IMM;
        w_alu_control = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_next        = S_IMM_WB;
      end
      S_IMM_WB: begin
        w_reg_dst    = DST_RT;
        w_mem_to_reg = WB_ALUOUT;
        w_reg_write  = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      S_JAL: begin
        // PC was already advanced in FETCH_IR, so it is the link value.
        w_pc_src     = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_reg_write  = 1'b1;
        w_reg_dst    = DST_RA;
        w_mem_to_reg = WB_PC;
      end
      S_JR: begin
        // rs OR $zero passes rs straight through to the PC.
        w_alu_srca    = SRCA_RS;
        w_alu_srcb    = SRCB_RT;
        w_alu_control = ALU_OR;
        w_pc_src      = PCSRC_ALU;
        w_pc_write    = 1'b1;
      end
`ifdef MCU_ILLEGAL_HALT_EN
      S_HALT: w_next = S_HALT;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  assign IorD        = w_iord;
  assign MemWrite    = w_mem_write & ~rst;
  assign IRWrite     = w_ir_write  & ~rst;
  assign PCWrite     = w_pc_write  & ~rst;
  assign Branch      = w_branch    & ~rst;
  assign RegWrite    = w_reg_write & ~rst;
  assign ToggleEqual = w_toggle_equal;
  assign PCSrc       = w_pc_src;
  assign ALUControl  = w_alu_control;
  assign ALUSrcB     = w_alu_srcb;
  assign ALUSrcA     = w_alu_srca;
  assign RegDst      = w_reg_dst;
  assign MemtoReg    = w_mem_to_reg;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module  : tb_multicycle_control_fsm
// Self-checking bench for multicycle_control_fsm (default build).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual;
  logic [1:0] PCSrc, ALUSrcB, RegDst, MemtoReg;
  logic [2:0] ALUControl;
  logic       ALUSrcA, RegWrite;
  logic [4:0] state;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .ToggleEqual(ToggleEqual), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,PCWrite,Branch,ToggleEqual,PCSrc,ALUControl,ALUSrcB,ALUSrcA,RegWrite,RegDst,MemtoReg}
  logic [18:0] w_dut_out;
  assign w_dut_out = {IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual, PCSrc,
                      ALUControl, ALUSrcB, ALUSrcA, RegWrite, RegDst, MemtoReg};

  logic [4:0] w_strobes;
  assign w_strobes = {MemWrite, IRWrite, PCWrite, Branch, RegWrite};

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: path of states an instruction walks from FETCH back to FETCH.
  function automatic int path_len(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 8;
      6'b101011: return 6;
      6'b000000: return (fn == 6'b001000) ? 5 : 6;
      6'b000100, 6'b000101: return 5;
      6'b001000, 6'b001010: return 6;
      6'b000010, 6'b000011: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int path_state(input logic [5:0] op, input logic [5:0] fn, input int i);
    if (i < 4) return i;
    case (op)
      6'b100011: return i;
      6'b101011: return (i == 4) ? 4 : 8;
      6'b000000: return (fn == 6'b001000) ? 16 : ((i == 4) ? 9 : 10);
      6'b000100, 6'b000101: return 11;
      6'b001000, 6'b001010: return (i == 4) ? 12 : 13;
      6'b000010: return 14;
      6'b000011: return 15;
      default: return 0;
    endcase
  endfunction

  function automatic logic [18:0] exp_out(input int s, input logic [5:0] op, input logic [5:0] fn);
    logic iord, mw, irw, pcw, br, te, a, rw;
    logic [1:0] pcs, srcb, rd, mtr;
    logic [2:0] alu;
    {iord, mw, irw, pcw, br, te, a, rw} = 8'd0;
    pcs = 2'd0; srcb = 2'd0; rd = 2'd0; mtr = 2'd0; alu = 3'd0;
    case (s)
      1:  begin irw = 1; pcw = 1; srcb = 2'b01; alu = 3'b010; end
      3:  begin srcb = 2'b11; alu = 3'b010; end
      4:  begin a = 1; srcb = 2'b10; alu = 3'b010; end
      5, 6: iord = 1;
      7:  begin rw = 1; mtr = 2'b01; end
      8:  begin iord = 1; mw = 1; end
      9: begin
        a = 1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      10: begin rw = 1; rd = 2'b01; end
      11: begin a = 1; alu = 3'b110; br = 1; pcs = 2'b01; te = op[0]; end
      12: begin a = 1; srcb = 2'b10; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
      13: rw = 1;
      14: begin pcs = 2'b10; pcw = 1; end
      15: begin pcs = 2'b10; pcw = 1; rw = 1; rd = 2'b10; mtr = 2'b10; end
      16: begin a = 1; alu = 3'b001; pcw = 1; end
      default: ;
    endcase
    return {iord, mw, irw, pcw, br, te, pcs, alu, srcb, a, rw, rd, mtr};
  endfunction

  // Runs one instruction starting in FETCH, checking every cycle; ks=31 means no key check.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] ks, input logic [18:0] ko, input string nm);
    int s;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < path_len(op, fn); i++) begin
      s = path_state(op, fn, i);
      chk($sformatf("%s_state%0d", nm, i), 32'(state), 32'(s));
      chk($sformatf("%s_out%0d", nm, i), 32'(w_dut_out), 32'(exp_out(s, op, fn)));
      if (s == int'(ks)) chk($sformatf("%s_key", nm), 32'(w_dut_out), 32'(ko));
      @(posedge clk); #1;
    end
  endtask

  // Walks idx cycles into an instruction, then asserts rst mid-instruction.
  task automatic rst_at(input logic [5:0] op, input logic [5:0] fn, input int idx, input string nm);
    int s;
    opcode = op;
    funct  = fn;
    repeat (idx) begin @(posedge clk); #1; end
    s = path_state(op, fn, idx);
    chk({nm, "_pre_state"}, 32'(state), 32'(s));
    rst = 1'b1;
    #1;
    chk({nm, "_strobes_forced"}, 32'(w_strobes), 32'd0);
    chk({nm, "_state_held"}, 32'(state), 32'(s));
    @(posedge clk); #1;
    chk({nm, "_post_state"}, 32'(state), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  ks;
    logic [18:0] ko;
  } vec_t;

  vec_t tbl[13];
  logic [5:0] ops_known[9];
  logic [5:0] fns_known[6];

  initial begin
    tbl[0]  = '{6'b100011, 6'b000000, 5'd7,  19'b0_0_0_0_0_0_00_000_00_0_1_00_01}; // lw
    tbl[1]  = '{6'b101011, 6'b000000, 5'd8,  19'b1_1_0_0_0_0_00_000_00_0_0_00_00}; // sw
    tbl[2]  = '{6'b000000, 6'b100010, 5'd9,  19'b0_0_0_0_0_0_00_110_00_1_0_00_00}; // sub
    tbl[3]  = '{6'b000000, 6'b100100, 5'd9,  19'b0_0_0_0_0_0_00_000_00_1_0_00_00}; // and
    tbl[4]  = '{6'b000000, 6'b100101, 5'd10, 19'b0_0_0_0_0_0_00_000_00_0_1_01_00}; // or wb
    tbl[5]  = '{6'b000000, 6'b101010, 5'd9,  19'b0_0_0_0_0_0_00_111_00_1_0_00_00}; // slt
    tbl[6]  = '{6'b000101, 6'b000000, 5'd11, 19'b0_0_0_0_1_1_01_110_00_1_0_00_00}; // bne
    tbl[7]  = '{6'b000100, 6'b000000, 5'd11, 19'b0_0_0_0_1_0_01_110_00_1_0_00_00}; // beq
    tbl[8]  = '{6'b000011, 6'b000000, 5'd15, 19'b0_0_0_1_0_0_10_000_00_0_1_10_10}; // jal
    tbl[9]  = '{6'b000010, 6'b000000, 5'd14, 19'b0_0_0_1_0_0_10_000_00_0_0_00_00}; // j
    tbl[10] = '{6'b000000, 6'b001000, 5'd16, 19'b0_0_0_1_0_0_00_001_00_1_0_00_00}; // jr
    tbl[11] = '{6'b001010, 6'b000000, 5'd12, 19'b0_0_0_0_0_0_00_111_10_1_0_00_00}; // slti
    tbl[12] = '{6'b111111, 6'b000000, 5'd3,  19'b0_0_0_0_0_0_00_010_11_0_0_00_00}; // illegal
    ops_known = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                  6'b001000, 6'b001010, 6'b000010, 6'b000011};
    fns_known = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

    rst = 1'b1; opcode = 6'd0; funct = 6'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_state%0d", i), 32'(state), 32'd0);
      chk($sformatf("reset_strobes%0d", i), 32'(w_strobes), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].ks, tbl[i].ko, $sformatf("vec%0d", i));

    // Illegal opcode must land back in FETCH.
    chk("illegal_back_to_fetch", 32'(state), 32'd0);

    rst_at(6'b101011, 6'd0, 5, "rst_sw_memwrite");
    rst_at(6'b100011, 6'd0, 7, "rst_lw_regwrite");
    rst_at(6'b000100, 6'd0, 4, "rst_beq_branch");
    rst_at(6'b000010, 6'd0, 4, "rst_j_pcwrite");
    rst_at(6'b001000, 6'd0, 1, "rst_fetch_irwrite");

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops_known[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 1) == 0) ? 6'($urandom) : fns_known[$urandom_range(0, 5)];
      run_instr(op, fn, 5'd31, 19'd0, $sformatf("rnd%0d", n));
    end

    chk("final_fetch", 32'(state), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
